// File: rtl/regfile_write_queue_if.sv
// Write-back queue bus: datapath request side, register-file write port side, bypass lookup.
interface regfile_write_queue_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_reg;
   logic [WIDTH-1:0] in_data;
   logic             stall;
   logic [4:0]       writeReg;
   logic [WIDTH-1:0] writeData;
   logic             regWrite;
   logic [4:0]       lookup_reg;
   logic             lookup_hit;
   logic [WIDTH-1:0] lookup_data;
   logic [CNT_W-1:0] count;

   // Driver of requests, stall and lookups (datapath / testbench side).
   modport master (
      output in_valid, in_reg, in_data, stall, lookup_reg,
      input  in_ready, writeReg, writeData, regWrite, lookup_hit, lookup_data, count
   );

   // The queue itself.
   modport slave (
      input  in_valid, in_reg, in_data, stall, lookup_reg,
      output in_ready, writeReg, writeData, regWrite, lookup_hit, lookup_data, count
   );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order write-back queue feeding the register file write port, with youngest-match bypass.
module regfile_write_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned ZERO_REG = 31
) (
   input logic                  clk,
   input logic                  reset,
   regfile_write_queue_if.slave io_bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [4:0]  ZREG  = 5'(ZERO_REG);

   logic [WIDTH-1:0] r_data [DEPTH];
   logic [4:0]       r_reg  [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             w_pop;
   logic             w_ready;
   logic             w_push;
   logic [CNT_W-1:0] w_count_d;
   logic [PTR_W-1:0] w_slot [DEPTH];
   logic             w_hit;
   logic [WIDTH-1:0] w_hit_data;

   // Handshake, write port and next count; zero-register requests are accepted but not stored.
   always_comb begin
      w_pop   = (r_count != '0) && !io_bus.stall;
      w_ready = (r_count < CNT_W'(DEPTH)) || w_pop;
      w_push  = io_bus.in_valid && w_ready && (io_bus.in_reg != ZREG);
      unique case ({w_push, w_pop})
         2'b10:   w_count_d = r_count + CNT_W'(1);
         2'b01:   w_count_d = r_count - CNT_W'(1);
         default: w_count_d = r_count;
      endcase
   end

   // Slot i holds the i-th oldest entry; scanning oldest to youngest lets the youngest match win.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_slot[i] = r_head + PTR_W'(i);
      end
   end

   // Bypass lookup over every queued entry, including the head being written this cycle.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      if (io_bus.lookup_reg != ZREG) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[w_slot[i]] && (r_reg[w_slot[i]] == io_bus.lookup_reg)) begin
               w_hit      = 1'b1;
               w_hit_data = r_data[w_slot[i]];
            end
         end
      end
   end

   // Output drive; the write port is zeroed whenever no write is issued.
   always_comb begin
      io_bus.in_ready    = w_ready;
      io_bus.regWrite    = w_pop;
      io_bus.writeReg    = w_pop ? r_reg[r_head]  : '0;
      io_bus.writeData   = w_pop ? r_data[r_head] : '0;
      io_bus.lookup_hit  = w_hit;
      io_bus.lookup_data = w_hit_data;
      io_bus.count       = r_count;
   end

   // Queue state; push is applied after pop so a full queue can retire and refill one slot.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
         end
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_reg[r_tail]   <= io_bus.in_reg;
            r_data[r_tail]  <= io_bus.in_data;
            r_tail          <= r_tail + PTR_W'(1);
         end
         r_count <= w_count_d;
      end
   end
endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: queue-based reference model checked every cycle plus literal checks.
module tb_regfile_write_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned WIDTH = 64;

   typedef struct {
      logic [4:0]       rg;
      logic [WIDTH-1:0] data;
   } entry_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic cmp_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   entry_t mq[$];

   regfile_write_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   regfile_write_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ZERO_REG(31)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain FIFO of requests, updated from the inputs seen at each edge.
   always @(posedge clk) begin
      bit pop, rdy;
      if (!reset) begin
         mq.delete();
      end else begin
         pop = (mq.size() > 0) && !bus.stall;
         rdy = (mq.size() < DEPTH) || pop;
         if (pop) void'(mq.pop_front());
         if (bus.in_valid && rdy && bus.in_reg != 5'd31) mq.push_back('{bus.in_reg, bus.in_data});
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      bit               e_wr, e_hit;
      logic [4:0]       e_reg;
      logic [WIDTH-1:0] e_data, e_ldata;
      if (cmp_en) begin
         e_wr   = (mq.size() > 0) && !bus.stall;
         e_reg  = e_wr ? mq[0].rg : 5'd0;
         e_data = e_wr ? mq[0].data : '0;
         e_hit  = 1'b0;
         e_ldata = '0;
         if (bus.lookup_reg != 5'd31) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
               if (!e_hit && mq[i].rg == bus.lookup_reg) begin
                  e_hit   = 1'b1;
                  e_ldata = mq[i].data;
               end
            end
         end
         chk("m_count", 64'(bus.count), 64'(mq.size()));
         chk("m_regWrite", 64'(bus.regWrite), 64'(e_wr));
         chk("m_writeReg", 64'(bus.writeReg), 64'(e_reg));
         chk("m_writeData", bus.writeData, e_data);
         chk("m_in_ready", 64'(bus.in_ready), 64'((mq.size() < DEPTH) || e_wr));
         chk("m_lookup_hit", 64'(bus.lookup_hit), 64'(e_hit));
         chk("m_lookup_data", bus.lookup_data, e_ldata);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] r, input logic [63:0] d);
      bus.in_valid = 1'b1;
      bus.in_reg   = r;
      bus.in_data  = d;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_reg     = '0;
      bus.in_data    = '0;
      bus.stall      = 1'b0;
      bus.lookup_reg = 5'd0;
      cyc();
      cyc();
      reset  = 1'b1;
      cmp_en = 1'b1;

      // 1: reset with three entries queued
      bus.stall = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         push(5'(k), 64'(k));
         cyc();
      end
      bus.in_valid   = 1'b0;
      bus.lookup_reg = 5'd2;
      @(negedge clk);
      chk("t1_pre_count", 64'(bus.count), 64'd3);
      cyc();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("t1_count", 64'(bus.count), 64'd0);
      chk("t1_regWrite", 64'(bus.regWrite), 64'd0);
      chk("t1_in_ready", 64'(bus.in_ready), 64'd1);
      chk("t1_lookup_hit", 64'(bus.lookup_hit), 64'd0);
      cyc();

      // 2: single write, one-cycle latency
      bus.stall = 1'b0;
      push(5'd5, 64'hDEADBEEF);
      cyc();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t2_regWrite", 64'(bus.regWrite), 64'd1);
      chk("t2_writeReg", 64'(bus.writeReg), 64'd5);
      chk("t2_writeData", bus.writeData, 64'hDEADBEEF);
      cyc();
      @(negedge clk);
      chk("t2_regWrite_after", 64'(bus.regWrite), 64'd0);
      chk("t2_count_after", 64'(bus.count), 64'd0);
      cyc();

      // 3: fill under stall, then drain five writes back to back
      bus.stall = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         push(5'(k), 64'(k * 17));
         cyc();
      end
      push(5'd5, 64'(5 * 17));
      @(negedge clk);
      chk("t3_count_full", 64'(bus.count), 64'd4);
      chk("t3_in_ready_full", 64'(bus.in_ready), 64'd0);
      cyc();
      bus.stall = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("t3_drain_regWrite", 64'(bus.regWrite), 64'd1);
         chk("t3_drain_writeReg", 64'(bus.writeReg), 64'(k));
         cyc();
         bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("t3_idle_regWrite", 64'(bus.regWrite), 64'd0);
      cyc();

      // 4: writes to the zero register are swallowed
      push(5'd31, 64'h1234);
      @(negedge clk);
      chk("t4_in_ready", 64'(bus.in_ready), 64'd1);
      cyc();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t4_count", 64'(bus.count), 64'd0);
      chk("t4_regWrite", 64'(bus.regWrite), 64'd0);
      cyc();

      // 5: bypass picks the youngest match
      bus.stall = 1'b1;
      push(5'd7, 64'hA);
      cyc();
      push(5'd3, 64'hB);
      cyc();
      push(5'd7, 64'hC);
      cyc();
      bus.in_valid   = 1'b0;
      bus.lookup_reg = 5'd7;
      #1;
      chk("t5_hit7", 64'(bus.lookup_hit), 64'd1);
      chk("t5_data7", bus.lookup_data, 64'hC);
      bus.lookup_reg = 5'd3;
      #1;
      chk("t5_hit3", 64'(bus.lookup_hit), 64'd1);
      chk("t5_data3", bus.lookup_data, 64'hB);
      bus.lookup_reg = 5'd9;
      #1;
      chk("t5_hit9", 64'(bus.lookup_hit), 64'd0);
      chk("t5_data9", bus.lookup_data, 64'd0);
      bus.lookup_reg = 5'd31;
      #1;
      chk("t5_hit31", 64'(bus.lookup_hit), 64'd0);
      cyc();
      bus.stall = 1'b0;
      bus.lookup_reg = 5'd7;
      cyc();
      bus.stall = 1'b1;
      #1;
      chk("t5_after_drain_hit7", 64'(bus.lookup_hit), 64'd1);
      chk("t5_after_drain_data7", bus.lookup_data, 64'hC);
      chk("t5_after_drain_count", 64'(bus.count), 64'd2);
      bus.stall = 1'b0;
      cyc();
      cyc();
      cyc();

      // 6: full queue sustains push+pop, then mid-stream reset
      bus.stall = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         push(5'(k + 10), 64'(k + 256));
         cyc();
      end
      bus.stall = 1'b0;
      push(5'd9, 64'h99);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("t6_count", 64'(bus.count), 64'd4);
         chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
         if (k < 4) chk("t6_order", 64'(bus.writeReg), 64'(k + 11));
         else chk("t6_order", 64'(bus.writeReg), 64'd9);
         cyc();
      end
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t6_reset_regWrite", 64'(bus.regWrite), 64'd0);
      chk("t6_reset_count", 64'(bus.count), 64'd0);
      cyc();
      cyc();

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
